// File: rtl/noc_vc_merge_arb_if.sv
// Flit bus for the VC merge stage.
//
// Purpose: bundles the per-VC input handshake, the merged output handshake
// and the occupancy/grant status of noc_vc_merge_arb into one bus.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. Valid may rise without waiting for
// ready. The input side here does not require valid to be held until
// accepted; the arbiter simply samples whatever is offered each cycle.
//
// Signals:
//   i_clear        synchronous flush of FIFO and packet lock
//   i_valid/i_last per-VC flit valid / last-of-packet
//   i_flit         per-VC flit payload, packed [CHANNELS-1:0][DATA_WIDTH-1:0]
//   o_ready        per-VC accept, at most one bit high
//   o_valid/o_flit/o_last/o_vc_id  merged output flit and its source VC
//   i_ready        downstream accept
//   o_grant        current one-hot grant
//   o_count/o_almost_full/o_full   FIFO occupancy for credit flow control
//
// Modports: master = flit source/sink side, slave = the merge stage.
interface noc_vc_merge_arb_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int VC_ID_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                                 i_clear;
  logic [CHANNELS-1:0]                  i_valid;
  logic [CHANNELS-1:0]                  i_last;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  i_flit;
  logic [CHANNELS-1:0]                  o_ready;
  logic                                 o_valid;
  logic [DATA_WIDTH-1:0]                o_flit;
  logic                                 o_last;
  logic [VC_ID_W-1:0]                   o_vc_id;
  logic                                 i_ready;
  logic [CHANNELS-1:0]                  o_grant;
  logic [CNT_W-1:0]                     o_count;
  logic                                 o_almost_full;
  logic                                 o_full;

  modport master (
    output i_clear, i_valid, i_last, i_flit, i_ready,
    input  o_ready, o_valid, o_flit, o_last, o_vc_id, o_grant,
           o_count, o_almost_full, o_full
  );

  modport slave (
    input  i_clear, i_valid, i_last, i_flit, i_ready,
    output o_ready, o_valid, o_flit, o_last, o_vc_id, o_grant,
           o_count, o_almost_full, o_full
  );
endinterface

// File: rtl/noc_vc_merge_arb.sv
// Virtual-channel merge stage.
//
// Purpose: merges CHANNELS VC flit streams into one output stream through a
// round-robin arbiter (optionally holding the grant for a whole packet) and
// a first-word-fall-through FIFO whose entries carry {vc_id, last, flit}.
//
// Ports:
//   noc_clk         clock
//   noc_rst         synchronous active-high reset
//   bus             noc_vc_merge_arb_if.slave (handshakes and status)
//   dbg_lock_state  1 while the arbiter holds a packet lock
module noc_vc_merge_arb #(
  parameter int CHANNELS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 8,
  parameter int THRESHOLD   = DEPTH - 2,
  parameter int PACKET_LOCK = 1,
  parameter int VC_ID_W     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst,
  noc_vc_merge_arb_if.slave        bus,
  output logic                     dbg_lock_state
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = VC_ID_W + 1 + DATA_WIDTH;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

  lock_state_t         state_q, state_d;
  logic [VC_ID_W-1:0]  lock_vc_q, lock_vc_d;
  logic [VC_ID_W-1:0]  rr_q, rr_d;
  logic [VC_ID_W-1:0]  gnt_idx, gnt_next;
  logic                gnt_found;
  int                  cand;
  logic [CHANNELS-1:0] grant, ready;
  logic                accept_en, push, push_last, pop, full, empty, out_valid;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    head;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  // Grant: the locked VC while a packet is in flight, otherwise the first
  // valid VC at or after the round-robin pointer (wrapping past CHANNELS-1).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    if (state_q == ST_LOCKED) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_vc_q;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand = int'(rr_q) + k;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        if (!gnt_found && bus.i_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = VC_ID_W'(cand);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      grant[c] = gnt_found && (gnt_idx == VC_ID_W'(c));
    end
  end

  assign gnt_next  = (gnt_idx == VC_ID_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  // No pass-through: a pop in the same cycle does not free a slot when full.
  assign accept_en = ~full & ~bus.i_clear & ~noc_rst;
  assign ready     = grant & {CHANNELS{accept_en}};
  assign push      = |(bus.i_valid & ready);
  assign push_last = bus.i_last[gnt_idx];
  assign pop       = ~empty & bus.i_ready;

  // Lock / round-robin next state.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    if (push) begin
      if (PACKET_LOCK != 0) begin
        if (push_last) begin
          state_d = ST_OPEN;
          rr_d    = gnt_next;
        end else begin
          state_d   = ST_LOCKED;
          lock_vc_d = gnt_idx;
        end
      end else begin
        rr_d = gnt_next;
      end
    end
  end

  // Clear flushes the lock but keeps the round-robin position.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q   <= ST_OPEN;
      lock_vc_q <= '0;
      rr_q      <= '0;
    end else if (bus.i_clear) begin
      state_q   <= ST_OPEN;
      lock_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_q      <= rr_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst || bus.i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge noc_clk) begin
    if (push) mem[wr_ptr] <= {gnt_idx, push_last, bus.i_flit[gnt_idx]};
  end

  assign head      = mem[rd_ptr];
  assign out_valid = ~noc_rst & ~empty;

  assign bus.o_ready       = ready;
  assign bus.o_grant       = noc_rst ? '0 : grant;
  assign bus.o_valid       = out_valid;
  assign bus.o_flit        = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign bus.o_last        = out_valid & head[DATA_WIDTH];
  assign bus.o_vc_id       = out_valid ? head[ENT_W-1 -: VC_ID_W] : '0;
  assign bus.o_count       = noc_rst ? '0 : count;
  assign bus.o_full        = ~noc_rst & full;
  assign bus.o_almost_full = ~noc_rst & (count >= CNT_W'(THRESHOLD));
  assign dbg_lock_state    = ~noc_rst & (state_q == ST_LOCKED);
endmodule
